// File: rtl/seven_seg_pkg.sv
// Shared glyph table for the seven-segment scan driver.
// Segment order is {a,b,c,d,e,f,g}, active low.
package seven_seg_pkg;

  localparam logic [6:0] GLYPH_0     = 7'b0000001;
  localparam logic [6:0] GLYPH_1     = 7'b1001111;
  localparam logic [6:0] GLYPH_2     = 7'b0010010;
  localparam logic [6:0] GLYPH_3     = 7'b0000110;
  localparam logic [6:0] GLYPH_4     = 7'b1001100;
  localparam logic [6:0] GLYPH_5     = 7'b0100100;
  localparam logic [6:0] GLYPH_6     = 7'b0100000;
  localparam logic [6:0] GLYPH_7     = 7'b0001111;
  localparam logic [6:0] GLYPH_8     = 7'b0000000;
  localparam logic [6:0] GLYPH_9     = 7'b0000100;
  localparam logic [6:0] GLYPH_A     = 7'b0001000;
  localparam logic [6:0] GLYPH_B     = 7'b1100000;
  localparam logic [6:0] GLYPH_C     = 7'b0110001;
  localparam logic [6:0] GLYPH_D     = 7'b1000010;
  localparam logic [6:0] GLYPH_E     = 7'b0110000;
  localparam logic [6:0] GLYPH_F     = 7'b0111000;
  localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

  function automatic logic [6:0] seg_decode(input logic [3:0] val, input logic hex_mode);
    logic [6:0] seg;
    case (val)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      4'hF: seg = GLYPH_F;
    endcase
    // Decimal-only displays show nothing for values above nine.
    if (!hex_mode && (val > 4'd9)) seg = GLYPH_BLANK;
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_glyph.sv
// Combinational 4-bit value to active-low seven-segment glyph decoder.
module seven_seg_glyph
  import seven_seg_pkg::*;
(
  input  logic [3:0] val_i,
  input  logic       hex_mode_i,
  output logic [6:0] seg_o
);

  assign seg_o = seg_decode(val_i, hex_mode_i);

endmodule

// File: rtl/seven_segment_scan.sv
// Multiplexed N-digit seven-segment driver with frame-synchronous loading,
// leading-zero blanking, per-digit enables/decimal points and anti-ghost guard.
module seven_segment_scan
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS       = 8,
  parameter int REFRESH_DIV      = 100000,
  parameter int GUARD            = 2,
  parameter int HEX_MODE         = 1,
  parameter int BLANK_LEADING    = 1,
  parameter int ANODE_ACTIVE_LOW = 1
) (
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic [4*NUM_DIGITS-1:0] NumIn,
  input  logic [NUM_DIGITS-1:0]   DpIn,
  input  logic [NUM_DIGITS-1:0]   DigitEn,
  input  logic                    Load,
  output logic [6:0]              SegOut,
  output logic                    DpOut,
  output logic [NUM_DIGITS-1:0]   AnOut,
  output logic                    FrameDone
);

  localparam int CNT_W  = $clog2(REFRESH_DIV);
  localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      CNT_LAST    = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      GUARD_START = CNT_W'(REFRESH_DIV - GUARD);
  localparam logic [SLOT_W-1:0]     SLOT_LAST   = SLOT_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF      = {NUM_DIGITS{ANODE_ACTIVE_LOW != 0}};

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] num;
    logic [NUM_DIGITS-1:0]   dp;
    logic [NUM_DIGITS-1:0]   en;
  } bank_t;

  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [SLOT_W-1:0]     slot_q, slot_d;
  bank_t                 pend_q, pend_d;
  bank_t                 shadow_q, shadow_d;
  logic                  pend_valid_q, pend_valid_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic                  frame_done_q;

  logic                  tick, boundary, in_guard, drive;
  logic [NUM_DIGITS-1:0] lead_blank, slot_onehot;
  logic [3:0]            slot_val;
  logic                  slot_dp, slot_on;
  logic [6:0]            slot_seg;

  assign tick     = (cnt_q == CNT_LAST);
  assign boundary = tick && (slot_q == SLOT_LAST);
  assign in_guard = (GUARD > 0) && (cnt_q >= GUARD_START);

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
    slot_d = slot_q;
    if (tick) slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
  end

  // Pending is copied to shadow before a same-cycle Load overwrites pending.
  always_comb begin
    pend_d       = pend_q;
    shadow_d     = shadow_q;
    pend_valid_d = pend_valid_q;
    if (boundary && pend_valid_q) begin
      shadow_d     = pend_q;
      pend_valid_d = 1'b0;
    end
    if (Load) begin
      pend_d       = '{num: NumIn, dp: DpIn, en: DigitEn};
      pend_valid_d = 1'b1;
    end
  end

  // Scan from the top slot down: a slot is leading while it and all above are zero with no DP.
  always_comb begin
    logic zero_run;
    zero_run   = 1'b1;
    lead_blank = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_run      = zero_run && (shadow_q.num[4*i +: 4] == 4'd0) && !shadow_q.dp[i];
      lead_blank[i] = (BLANK_LEADING != 0) && (i > 0) && zero_run;
    end
  end

  always_comb begin
    slot_val    = '0;
    slot_dp     = 1'b0;
    slot_on     = 1'b0;
    slot_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (slot_q == SLOT_W'(i)) begin
        slot_val       = shadow_q.num[4*i +: 4];
        slot_dp        = shadow_q.dp[i];
        slot_on        = shadow_q.en[i] && !lead_blank[i];
        slot_onehot[i] = 1'b1;
      end
    end
  end

  seven_seg_glyph u_glyph (
    .val_i      (slot_val),
    .hex_mode_i (HEX_MODE != 0),
    .seg_o      (slot_seg)
  );

  always_comb begin
    drive = slot_on && !in_guard;
    seg_d = drive ? slot_seg : GLYPH_BLANK;
    dp_d  = !(drive && slot_dp);
    an_d  = AN_OFF ^ (drive ? slot_onehot : '0);
  end

  // NOTE: sequential state uses non-blocking assignments; the reset is asynchronous.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt_q        <= '0;
      slot_q       <= '0;
      pend_q       <= '0;
      shadow_q     <= '0;
      pend_valid_q <= 1'b0;
      seg_q        <= GLYPH_BLANK;
      dp_q         <= 1'b1;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      slot_q       <= slot_d;
      pend_q       <= pend_d;
      shadow_q     <= shadow_d;
      pend_valid_q <= pend_valid_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= boundary;
    end
  end

  assign SegOut    = seg_q;
  assign DpOut     = dp_q;
  assign AnOut     = an_q;
  assign FrameDone = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan.sv
// Self-checking bench: two driver instances (hex/blanking on, and hex/blanking off)
// compared every cycle against a frame-time model, plus literal per-slot expectations.
module tb_seven_segment_scan;

  localparam int N     = 4;
  localparam int DIV   = 6;
  localparam int GUARD = 1;
  localparam int FRAME = N * DIV;

  localparam logic [6:0] G0 = 7'b0000001, G1 = 7'b1001111, G2 = 7'b0010010, G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100, G5 = 7'b0100100, GA = 7'b0001000, GF = 7'b0111000;
  localparam logic [6:0] BL = 7'b1111111;

  logic        Clk   = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] NumIn = '0;
  logic [3:0]  DpIn = '0, DigitEn = '0;
  logic        Load = 1'b0;

  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, fd_a, fd_b;
  logic [3:0] an_a, an_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 Clk = ~Clk;

  seven_segment_scan #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD(GUARD), .HEX_MODE(1),
                       .BLANK_LEADING(1), .ANODE_ACTIVE_LOW(1)) dut_a (
    .Clk(Clk), .Reset(Reset), .NumIn(NumIn), .DpIn(DpIn), .DigitEn(DigitEn), .Load(Load),
    .SegOut(seg_a), .DpOut(dp_a), .AnOut(an_a), .FrameDone(fd_a));

  seven_segment_scan #(.NUM_DIGITS(N), .REFRESH_DIV(DIV), .GUARD(GUARD), .HEX_MODE(0),
                       .BLANK_LEADING(0), .ANODE_ACTIVE_LOW(1)) dut_b (
    .Clk(Clk), .Reset(Reset), .NumIn(NumIn), .DpIn(DpIn), .DigitEn(DigitEn), .Load(Load),
    .SegOut(seg_b), .DpOut(dp_b), .AnOut(an_b), .FrameDone(fd_b));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       fd;
  } out_t;

  typedef struct packed {
    logic [3:0]  en;
    logic [3:0]  dp;
    logic [15:0] num;
  } tbank_t;

  localparam out_t RST_OUT = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, fd: 1'b0};

  logic [6:0] glyph_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                                 7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  int     n_edges;
  tbank_t m_pend, m_shad;
  bit     m_pvalid;
  out_t   exp_a = RST_OUT, exp_b = RST_OUT;

  // What the display must show for frame position pos, derived from the display rules.
  function automatic out_t model_out(input bit hex, input bit blank_lead, input int pos,
                                     input tbank_t b);
    out_t       o;
    int         slot;
    logic [3:0] v;
    bit         blanked;
    o    = '{seg: 7'h7F, dp: 1'b1, an: 4'hF, fd: (pos == FRAME - 1)};
    slot = pos / DIV;
    if ((pos % DIV) >= DIV - GUARD) return o;
    if (!b.en[slot]) return o;
    blanked = 1'b0;
    if (blank_lead && slot > 0) begin
      blanked = 1'b1;
      for (int j = slot; j < N; j++)
        if (b.num[4*j +: 4] != 4'd0 || b.dp[j]) blanked = 1'b0;
    end
    if (blanked) return o;
    v     = b.num[4*slot +: 4];
    o.seg = (v >= 4'd10 && !hex) ? 7'h7F : glyph_tab[v];
    o.dp  = ~b.dp[slot];
    o.an  = ~(4'b0001 << slot);
    return o;
  endfunction

  always @(posedge Clk or posedge Reset) begin : model
    int pos;
    if (Reset) begin
      n_edges  = 0;
      m_pend   = '0;
      m_shad   = '0;
      m_pvalid = 1'b0;
      exp_a    = RST_OUT;
      exp_b    = RST_OUT;
    end else begin
      pos   = n_edges % FRAME;
      exp_a = model_out(1'b1, 1'b1, pos, m_shad);
      exp_b = model_out(1'b0, 1'b0, pos, m_shad);
      if (pos == FRAME - 1 && m_pvalid) begin
        m_shad   = m_pend;
        m_pvalid = 1'b0;
      end
      if (Load) begin
        m_pend   = {DigitEn, DpIn, NumIn};
        m_pvalid = 1'b1;
      end
      n_edges++;
    end
  end

  always @(negedge Clk) begin
    check("model seg_a", seg_a, exp_a.seg);
    check("model dp_a",  dp_a,  exp_a.dp);
    check("model an_a",  an_a,  exp_a.an);
    check("model fd_a",  fd_a,  exp_a.fd);
    check("model seg_b", seg_b, exp_b.seg);
    check("model dp_b",  dp_b,  exp_b.dp);
    check("model an_b",  an_b,  exp_b.an);
    check("model fd_b",  fd_b,  exp_b.fd);
  end

  // ---------------- directed literal checks ----------------
  // Call at the negedge where FrameDone is high; returns at the next such negedge.
  // segs_* = {slot3,slot2,slot1,slot0}; vis_* = slots whose anode must assert.
  // Loads (bank {en,dp,num}) are applied on the edge following offset lo1/lo2.
  task automatic check_frame(input logic [27:0] segs_a, input logic [3:0] vis_a,
                             input logic [27:0] segs_b, input logic [3:0] vis_b,
                             input logic [3:0] dp_bits,
                             input int lo1, input logic [23:0] ld1,
                             input int lo2, input logic [23:0] ld2);
    int         s, c;
    logic [3:0] an_on;
    logic       dp_on;
    for (int off = 1; off <= FRAME; off++) begin
      @(negedge Clk);
      s     = (off - 1) / DIV;
      c     = (off - 1) % DIV;
      an_on = 4'b0001 << s;
      an_on = ~an_on;
      dp_on = ~dp_bits[s];
      check("frame_done_a", fd_a, off == FRAME);
      check("frame_done_b", fd_b, off == FRAME);
      if (c == 0) begin
        check("slot seg_a", seg_a, vis_a[s] ? segs_a[7*s +: 7] : BL);
        check("slot an_a",  an_a,  vis_a[s] ? an_on : 4'hF);
        check("slot dp_a",  dp_a,  vis_a[s] ? dp_on : 1'b1);
        check("slot seg_b", seg_b, vis_b[s] ? segs_b[7*s +: 7] : BL);
        check("slot an_b",  an_b,  vis_b[s] ? an_on : 4'hF);
        check("slot dp_b",  dp_b,  vis_b[s] ? dp_on : 1'b1);
      end else if (c == DIV - 1) begin
        check("guard seg_a", seg_a, BL);
        check("guard an_a",  an_a,  4'hF);
        check("guard seg_b", seg_b, BL);
        check("guard an_b",  an_b,  4'hF);
      end
      Load = 1'b0;
      if (off == lo1) begin {DigitEn, DpIn, NumIn} = ld1; Load = 1'b1; end
      if (off == lo2) begin {DigitEn, DpIn, NumIn} = ld2; Load = 1'b1; end
    end
    Load = 1'b0;
  endtask

  // Call at the negedge where Reset is released; FrameDone must appear exactly one frame later.
  task automatic after_reset();
    for (int i = 1; i <= FRAME; i++) begin
      @(negedge Clk);
      check("post-reset fd_a", fd_a, i == FRAME);
      check("post-reset fd_b", fd_b, i == FRAME);
    end
  endtask

  initial begin
    Reset = 1'b1;
    repeat (2) @(negedge Clk);
    check("reset seg_a", seg_a, BL);
    check("reset an_a",  an_a,  4'hF);
    check("reset dp_a",  dp_a,  1'b1);
    Reset = 1'b0;
    after_reset();

    // Empty shadow after reset: nothing lit. Queue 12AF.
    check_frame('0, 4'b0000, '0, 4'b0000, 4'b0000, 3, {4'hF, 4'h0, 16'h12AF}, 0, '0);
    // Hex glyphs on A, decimal-only instance blanks 10..15 but keeps anodes.
    check_frame({G1, G2, GA, GF}, 4'b1111, {G1, G2, BL, BL}, 4'b1111, 4'b0000,
                3, {4'hF, 4'h0, 16'h0005}, 0, '0);
    // Leading-zero blanking leaves only slot 0 on A.
    check_frame({BL, BL, BL, G5}, 4'b0001, {G0, G0, G0, G5}, 4'b1111, 4'b0000,
                3, {4'hF, 4'b0100, 16'h0005}, 0, '0);
    // A decimal point on slot 2 stops blanking at slot 2.
    check_frame({BL, G0, G0, G5}, 4'b0111, {G0, G0, G0, G5}, 4'b1111, 4'b0100,
                3, {4'b0101, 4'b1001, 16'h12AF}, 0, '0);
    // Disabled slots 1 and 3 stay dark.
    check_frame({G1, G2, GA, GF}, 4'b0101, {G1, G2, BL, BL}, 4'b0101, 4'b1001,
                3, {4'hF, 4'h0, 16'h1111}, 0, '0);
    // A mid-frame load does not disturb the frame being shown.
    check_frame({G1, G1, G1, G1}, 4'b1111, {G1, G1, G1, G1}, 4'b1111, 4'b0000,
                8, {4'hF, 4'h0, 16'h2222}, 0, '0);
    // Queue 3333, then load 4444 on the boundary edge itself.
    check_frame({G2, G2, G2, G2}, 4'b1111, {G2, G2, G2, G2}, 4'b1111, 4'b0000,
                3, {4'hF, 4'h0, 16'h3333}, FRAME - 1, {4'hF, 4'h0, 16'h4444});
    check_frame({G3, G3, G3, G3}, 4'b1111, {G3, G3, G3, G3}, 4'b1111, 4'b0000, 0, '0, 0, '0);
    check_frame({G4, G4, G4, G4}, 4'b1111, {G4, G4, G4, G4}, 4'b1111, 4'b0000, 0, '0, 0, '0);

    // Reset in the middle of slot 1 clears outputs within the same cycle.
    repeat (8) @(negedge Clk);
    check("pre-reset an_a", an_a, 4'b1101);
    #2 Reset = 1'b1;
    #1;
    check("mid reset seg_a", seg_a, BL);
    check("mid reset dp_a",  dp_a,  1'b1);
    check("mid reset an_a",  an_a,  4'hF);
    check("mid reset fd_a",  fd_a,  1'b0);
    check("mid reset an_b",  an_b,  4'hF);
    @(negedge Clk);
    Reset = 1'b0;
    after_reset();
    check_frame('0, 4'b0000, '0, 4'b0000, 4'b0000, 0, '0, 0, '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
